// File: rtl/ram_burst_reader_512x32_if.sv
// Bus bundle for the burst reader: command inputs, RAM read port and the valid/ready output stage.
interface ram_burst_reader_512x32_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 10
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic                  abort;

  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic                  ram_out_en;
  logic [DATA_WIDTH-1:0] ram_dout;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic                  m_last;

  logic                  busy;
  logic                  done;

  // Reader side
  modport slave (
    input  start, base_addr, len, abort, ram_dout, m_ready,
    output ram_read_addr, ram_out_en, m_valid, m_data, m_addr, m_last, busy, done
  );

  // Command issuer / RAM / downstream consumer side
  modport master (
    output start, base_addr, len, abort, ram_dout, m_ready,
    input  ram_read_addr, ram_out_en, m_valid, m_data, m_addr, m_last, busy, done
  );
endinterface

// File: rtl/ram_burst_reader_512x32.sv
// Burst read sequencer for a 512x32 async-read RAM: walks addresses from a base with wrap,
// registering each word into a valid/ready stage tagged with its address and a last flag.
module ram_burst_reader_512x32 #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  ram_burst_reader_512x32_if.slave    bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_ram_read_addr;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [LEN_WIDTH-1:0]  w_len_clamped;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic                  r_busy;
  logic                  r_ram_out_en;
  logic                  r_done;
  logic                  w_cap;
  logic                  w_accept;
  logic                  w_last_cap;
  logic                  w_drain_hs;

  // Next-state and handshake decode
  always_comb begin
    w_next_state  = r_state;
    w_cap         = !r_m_valid || bus.m_ready;
    w_accept      = bus.start && (bus.len != '0);
    w_last_cap    = w_cap && (r_remaining == LEN_WIDTH'(1));
    w_drain_hs    = r_m_valid && bus.m_ready;
    w_len_clamped = (bus.len > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : bus.len;

    if (bus.abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept)   w_next_state = S_READ;
        S_READ:  if (w_last_cap) w_next_state = S_DRAIN;
        S_DRAIN: if (w_drain_hs) w_next_state = S_IDLE;
        default:                 w_next_state = S_IDLE;
      endcase
    end
  end

  // State register; busy and RAM enable follow the registered state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_ram_out_en <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_busy       <= (w_next_state != S_IDLE);
      r_ram_out_en <= (w_next_state == S_READ);
    end
  end

  // Address walker and output stage; the read address only moves on a capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ram_read_addr <= '0;
      r_m_data        <= '0;
      r_m_addr        <= '0;
      r_m_valid       <= 1'b0;
      r_m_last        <= 1'b0;
      r_remaining     <= '0;
      r_done          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_m_valid   <= 1'b0;
        r_m_last    <= 1'b0;
        r_remaining <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_ram_read_addr <= bus.base_addr;
              r_remaining     <= w_len_clamped;
            end
          end
          S_READ: begin
            if (w_cap) begin
              r_m_data        <= bus.ram_dout;
              r_m_addr        <= r_ram_read_addr;
              r_m_valid       <= 1'b1;
              r_m_last        <= (r_remaining == LEN_WIDTH'(1));
              r_remaining     <= r_remaining - LEN_WIDTH'(1);
              r_ram_read_addr <= r_ram_read_addr + ADDR_WIDTH'(1);
            end
          end
          S_DRAIN: begin
            if (w_drain_hs) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_done    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ram_read_addr = r_ram_read_addr;
  assign bus.ram_out_en    = r_ram_out_en;
  assign bus.m_valid       = r_m_valid;
  assign bus.m_data        = r_m_data;
  assign bus.m_addr        = r_m_addr;
  assign bus.m_last        = r_m_last;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_ram_burst_reader_512x32.sv
// Self-checking bench for ram_burst_reader_512x32: burst-level queue model, vector table,
// randomized bursts/back-pressure and hand-written abort/reset/boundary sequences.
module tb_ram_burst_reader_512x32;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 10;
  localparam int          DEPTH = 512;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ram_burst_reader_512x32_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  ram_burst_reader_512x32 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model with asynchronous read
  logic [DW-1:0] mem [DEPTH];
  assign bus.ram_dout = mem[bus.ram_read_addr];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  typedef struct {
    int base;
    int len;
    int exp_words;
    int exp_first;
    int exp_last;
  } vec_t;

  word_t exp_q[$];
  word_t mon_w;
  vec_t  vecs [5];

  int n_tests  = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;
  int last_cnt = 0;
  int ready_mode = 0;
  int ready_ph   = 0;
  int d0;
  logic [AW-1:0] first_addr, last_addr;
  bit            first_seen = 1'b0;

  logic          p_stall = 1'b0;
  logic          p_oe    = 1'b0;
  logic          p_done  = 1'b0;
  logic [AW-1:0] p_addr, p_raddr;
  logic [DW-1:0] p_data;
  logic          p_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected word sequence straight from the burst rules
  task automatic model_burst(input int base, input int len);
    int n;
    n = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < n; i++) begin
      word_t w;
      w.addr = AW'((base + i) % DEPTH);
      w.data = mem[w.addr];
      w.last = (i == n - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    hs_cnt     = 0;
    last_cnt   = 0;
    first_seen = 1'b0;
    d0         = done_cnt;
  endtask

  task automatic start_burst(input int base, input int len);
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.len       = LW'(len);
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (done_cnt == d0 && c < budget) begin
      tick();
      c++;
    end
    tick(2);
    check("done_count", done_cnt - d0, 1);
  endtask

  // Downstream ready: always, random, or the 1,0,0 pattern
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.m_ready = 1'b1;
      1: bus.m_ready = ($urandom_range(99) < 70);
      2: begin
        bus.m_ready = ((ready_ph % 3) == 0);
        ready_ph++;
      end
      default: bus.m_ready = 1'b0;
    endcase
  end

  // Consumer-side monitor and scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (p_stall) begin
        check("stall_valid", bus.m_valid, 1);
        check("stall_addr", bus.m_addr, p_addr);
        check("stall_data", bus.m_data, p_data);
        check("stall_last", bus.m_last, p_last);
        if (p_oe) check("stall_raddr", bus.ram_read_addr, p_raddr);
      end
      if (bus.m_valid && bus.m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_word: got addr 0x%0h, expected no word", bus.m_addr);
        end else begin
          mon_w = exp_q.pop_front();
          check("word_addr", bus.m_addr, mon_w.addr);
          check("word_data", bus.m_data, mon_w.data);
          check("word_last", bus.m_last, mon_w.last);
        end
        if (!first_seen) begin
          first_addr = bus.m_addr;
          first_seen = 1'b1;
        end
        if (bus.m_last) begin
          last_cnt++;
          last_addr = bus.m_addr;
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("done_busy_low", bus.busy, 0);
        check("done_single", p_done, 0);
      end
      p_stall = bus.m_valid && !bus.m_ready && !bus.abort;
      p_oe    = bus.ram_out_en;
      p_addr  = bus.m_addr;
      p_data  = bus.m_data;
      p_last  = bus.m_last;
      p_raddr = bus.ram_read_addr;
      p_done  = bus.done;
    end else begin
      p_stall = 1'b0;
      p_done  = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base, len, n;

    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.m_ready   = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) * 32'h0101_0101;

    vecs[0] = '{base: 510, len: 4,   exp_words: 4,   exp_first: 510, exp_last: 1};
    vecs[1] = '{base: 7,   len: 600, exp_words: 512, exp_first: 7,   exp_last: 6};
    vecs[2] = '{base: 0,   len: 512, exp_words: 512, exp_first: 0,   exp_last: 511};
    vecs[3] = '{base: 300, len: 1,   exp_words: 1,   exp_first: 300, exp_last: 300};
    vecs[4] = '{base: 511, len: 2,   exp_words: 2,   exp_first: 511, exp_last: 0};

    // Reset held with start toggling
    repeat (10) begin
      @(posedge clk);
      #1;
      bus.start = ~bus.start;
      bus.len   = LW'(5);
    end
    check("rst_raddr", bus.ram_read_addr, 0);
    check("rst_mdata", bus.m_data, 0);
    check("rst_maddr", bus.m_addr, 0);
    check("rst_oe", bus.ram_out_en, 0);
    check("rst_valid", bus.m_valid, 0);
    check("rst_last", bus.m_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    bus.start = 1'b0;
    reset     = 1'b1;
    tick(2);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_valid", bus.m_valid, 0);

    // Cycle-exact burst base 0, len 8
    ready_mode = 0;
    tick();
    clear_counts();
    model_burst(0, 8);
    start_burst(0, 8);
    check("e0_busy", bus.busy, 1);
    check("e0_oe", bus.ram_out_en, 1);
    check("e0_valid", bus.m_valid, 0);
    check("e0_raddr", bus.ram_read_addr, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("seq_valid", bus.m_valid, 1);
      check("seq_addr", bus.m_addr, k - 1);
      check("seq_data", bus.m_data, (k - 1) * 32'h0101_0101);
      check("seq_last", bus.m_last, (k == 8));
      check("seq_done", bus.done, 0);
    end
    tick();
    check("e9_done", bus.done, 1);
    check("e9_busy", bus.busy, 0);
    check("e9_valid", bus.m_valid, 0);
    tick();
    check("e10_done", bus.done, 0);
    check("seq_words", hs_cnt, 8);
    check("seq_lasts", last_cnt, 1);
    check("seq_queue", exp_q.size(), 0);

    // Back-pressure 1,0,0 pattern
    ready_ph   = 0;
    ready_mode = 2;
    clear_counts();
    model_burst(5, 4);
    start_burst(5, 4);
    wait_done(200);
    check("bp_words", hs_cnt, 4);
    check("bp_first", first_addr, 5);
    check("bp_last", last_addr, 8);
    check("bp_queue", exp_q.size(), 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    // Vector table: wrap, clamp, full sweep, single word
    for (int i = 0; i < 5; i++) begin
      ready_mode = (i % 2 == 0) ? 0 : 1;
      clear_counts();
      model_burst(vecs[i].base, vecs[i].len);
      start_burst(vecs[i].base, vecs[i].len);
      wait_done(3000);
      check("vec_words", hs_cnt, vecs[i].exp_words);
      check("vec_first", first_addr, vecs[i].exp_first);
      check("vec_last", last_addr, vecs[i].exp_last);
      check("vec_lasts", last_cnt, 1);
      check("vec_queue", exp_q.size(), 0);
    end

    // Randomized bursts under random back-pressure
    ready_mode = 1;
    for (int r = 0; r < 20; r++) begin
      base = int'($urandom_range(DEPTH - 1));
      len  = (r % 7 == 6) ? int'($urandom_range(1023, 500)) : int'($urandom_range(40, 1));
      n    = (len > DEPTH) ? DEPTH : len;
      clear_counts();
      model_burst(base, len);
      start_burst(base, len);
      wait_done(3000);
      check("rnd_words", hs_cnt, n);
      check("rnd_last", last_addr, (base + n - 1) % DEPTH);
      check("rnd_queue", exp_q.size(), 0);
    end
    ready_mode = 0;
    tick(2);

    // len 0 is ignored
    clear_counts();
    start_burst(33, 0);
    check("len0_busy", bus.busy, 0);
    tick(3);
    check("len0_busy_later", bus.busy, 0);
    check("len0_valid", bus.m_valid, 0);
    check("len0_no_done", done_cnt - d0, 0);

    // start during a burst is ignored
    clear_counts();
    model_burst(20, 6);
    start_burst(20, 6);
    tick(2);
    start_burst(300, 3);
    wait_done(100);
    check("busy_start_words", hs_cnt, 6);
    check("busy_start_queue", exp_q.size(), 0);

    // start in the done cycle is accepted
    clear_counts();
    model_burst(40, 3);
    start_burst(40, 3);
    c = 0;
    while (!bus.done && c < 50) begin
      tick();
      c++;
    end
    check("done_seen", bus.done, 1);
    model_burst(200, 2);
    start_burst(200, 2);
    check("done_start_busy", bus.busy, 1);
    d0 = done_cnt;
    wait_done(100);
    check("done_start_words", hs_cnt, 5);
    check("done_start_queue", exp_q.size(), 0);

    // abort on the third word
    clear_counts();
    model_burst(0, 16);
    start_burst(0, 16);
    c = 0;
    while (!(bus.m_valid && bus.m_addr == AW'(2)) && c < 50) begin
      tick();
      c++;
    end
    check("abort_at_word2", bus.m_addr, 2);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_valid", bus.m_valid, 0);
    check("abort_last", bus.m_last, 0);
    check("abort_oe", bus.ram_out_en, 0);
    check("abort_busy", bus.busy, 0);
    exp_q.delete();
    check("abort_words", hs_cnt, 3);
    tick(3);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", bus.busy, 0);
    clear_counts();
    model_burst(100, 2);
    start_burst(100, 2);
    wait_done(100);
    check("post_abort_words", hs_cnt, 2);
    check("post_abort_last", last_addr, 101);

    // reset mid-burst
    clear_counts();
    model_burst(50, 16);
    start_burst(50, 16);
    tick(4);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_valid", bus.m_valid, 0);
    tick();
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_raddr", bus.ram_read_addr, 0);
    reset = 1'b1;
    exp_q.delete();
    tick(3);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_idle_valid", bus.m_valid, 0);
    clear_counts();
    model_burst(100, 2);
    start_burst(100, 2);
    wait_done(100);
    check("post_rst_words", hs_cnt, 2);
    check("post_rst_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
